// File: rtl/cordic_share_arbiter.sv
// Round-robin share of one CORDIC core among N_REQ sin/cos requesters.
// Build option: CORDIC_ARB_WATCHDOG_EN adds a WAIT-state abort watchdog.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req / req_operation        per-requester request level and op (1=sin)
//   req_data                   angles, slot i = req_data[i*W +: W]
//   done / result / grant_idx  per-requester result handshake
//   busy                       transaction in progress
//   beg_FSM_CORDIC, operation,
//   data_in, ready_CORDIC,
//   data_out, ACK_FSM_CORDIC   core-side handshake
//   err_timeout                watchdog abort flag (0 without the option)
module cordic_share_arbiter #(
  parameter int N_REQ       = 4,
  parameter int W           = 32,
  parameter int TIMEOUT_CYC = 255,
  localparam int GW         = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] req_operation,
  input  logic [N_REQ*W-1:0] req_data,
  output logic [N_REQ-1:0] done,
  output logic [W-1:0]     result,
  output logic [GW-1:0]    grant_idx,
  output logic             busy,
  output logic             beg_FSM_CORDIC,
  output logic             operation,
  output logic [W-1:0]     data_in,
  input  logic             ready_CORDIC,
  input  logic [W-1:0]     data_out,
  output logic             ACK_FSM_CORDIC,
  output logic             err_timeout
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_ACK     = 3'd3,
    S_DELIVER = 3'd4
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [GW-1:0]   rr_ptr;
  logic [GW-1:0]   pick;
  logic            found;
  logic            wd_hit;
  logic            grant_rel;

  // Round-robin search starting at rr_ptr.
  always_comb begin
    int j;
    logic [GW-1:0] idx;
    j     = 0;
    idx   = '0;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      idx = GW'(j);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign grant_rel = !req[grant_idx];

`ifdef CORDIC_ARB_WATCHDOG_EN
  logic [7:0] wd_cnt;
  logic       err_q;

  // wd_cnt counts completed WAIT cycles; abort on the
  // TIMEOUT_CYC-th cycle that still lacks ready.
  assign wd_hit = (state == S_WAIT) && !ready_CORDIC &&
                  (wd_cnt == 8'(TIMEOUT_CYC - 1));
  assign err_timeout = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state == S_WAIT) wd_cnt <= wd_cnt + 8'd1;
      else                 wd_cnt <= '0;
      if (state == S_IDLE && found) err_q <= 1'b0;
      else if (wd_hit)              err_q <= 1'b1;
    end
  end
`else
  logic [7:0] unused_timeout;
  assign unused_timeout = 8'(TIMEOUT_CYC);
  assign wd_hit      = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = S_IDLE;
    case (state)
      S_IDLE:    state_nx = found ? S_ISSUE : S_IDLE;
      S_ISSUE:   state_nx = S_WAIT;
      S_WAIT: begin
        if (ready_CORDIC || wd_hit) state_nx = S_ACK;
        else                        state_nx = S_WAIT;
      end
      S_ACK:     state_nx = S_DELIVER;
      S_DELIVER: state_nx = grant_rel ? S_IDLE : S_DELIVER;
      default:   state_nx = S_IDLE;
    endcase
  end

  // Latched transaction context and captured result.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr    <= '0;
      grant_idx <= '0;
      operation <= 1'b0;
      data_in   <= '0;
      result    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            grant_idx <= pick;
            operation <= req_operation[pick];
            data_in   <= req_data[int'(pick)*W +: W];
          end
        end
        S_WAIT: begin
          if (ready_CORDIC) result <= data_out;
          else if (wd_hit)  result <= '0;
        end
        S_DELIVER: begin
          if (grant_rel) begin
            if (grant_idx == GW'(N_REQ - 1)) rr_ptr <= '0;
            else rr_ptr <= grant_idx + GW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy           = (state != S_IDLE);
  assign beg_FSM_CORDIC = (state == S_ISSUE);
  assign ACK_FSM_CORDIC = (state == S_ACK);

  always_comb begin
    done = '0;
    if (state == S_DELIVER) done[grant_idx] = 1'b1;
  end

endmodule

// File: tb/tb_cordic_share_arbiter.sv
// Directed bench for cordic_share_arbiter with a simple core model.
// Table-driven arbitration vectors plus reset/angle/watchdog sequences.
module tb_cordic_share_arbiter;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    req;
  logic [3:0]    req_operation;
  logic [127:0]  req_data;
  logic [3:0]    done;
  logic [31:0]   result;
  logic [1:0]    grant_idx;
  logic          busy;
  logic          beg_FSM_CORDIC;
  logic          operation;
  logic [31:0]   data_in;
  logic          ready_CORDIC;
  logic [31:0]   data_out;
  logic          ACK_FSM_CORDIC;
  logic          err_timeout;

  cordic_share_arbiter #(
    .N_REQ(4), .W(32), .TIMEOUT_CYC(10)
  ) dut (
    .clk(clk), .reset(reset),
    .req(req), .req_operation(req_operation),
    .req_data(req_data), .done(done),
    .result(result), .grant_idx(grant_idx),
    .busy(busy), .beg_FSM_CORDIC(beg_FSM_CORDIC),
    .operation(operation), .data_in(data_in),
    .ready_CORDIC(ready_CORDIC), .data_out(data_out),
    .ACK_FSM_CORDIC(ACK_FSM_CORDIC),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Core model: ready rises core_lat cycles after beg,
  // holds until ACK.
  logic [31:0] core_res;
  int          core_lat;
  int          cnt;

  always @(posedge clk) begin
    if (reset) begin
      ready_CORDIC <= 1'b0;
      data_out     <= '0;
      cnt          <= 0;
    end else if (ACK_FSM_CORDIC) begin
      ready_CORDIC <= 1'b0;
      cnt          <= 0;
    end else if (beg_FSM_CORDIC) begin
      cnt      <= core_lat;
      data_out <= 32'hBAD0_BAD0;
    end else if (cnt > 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) begin
        ready_CORDIC <= 1'b1;
        data_out     <= core_res;
      end
    end
  end

  int beg_cnt = 0;
  int ack_cnt = 0;
  int onehot_bad = 0;

  always @(negedge clk) begin
    if (beg_FSM_CORDIC) beg_cnt++;
    if (ACK_FSM_CORDIC) ack_cnt++;
    if ($countones(done) > 1) onehot_bad++;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_beg"}, 32'(beg_FSM_CORDIC), 0);
    chk({tag, "_ack"}, 32'(ACK_FSM_CORDIC), 0);
    chk({tag, "_grant"}, 32'(grant_idx), 0);
    chk({tag, "_op"}, 32'(operation), 0);
    chk({tag, "_din"}, data_in, 0);
    chk({tag, "_res"}, result, 0);
    chk({tag, "_err"}, 32'(err_timeout), 0);
  endtask

  // Called at the negedge where inputs were just applied.
  task automatic serve(input string tag, input int g,
                       input logic op,
                       input logic [31:0] ang,
                       input logic [31:0] res);
    int b0, a0, t, t_rdy;
    b0 = beg_cnt;
    a0 = ack_cnt;
    @(negedge clk);
    chk({tag, "_beg"}, 32'(beg_FSM_CORDIC), 1);
    chk({tag, "_grant"}, 32'(grant_idx), 32'(g));
    chk({tag, "_op"}, 32'(operation), 32'(op));
    chk({tag, "_din"}, data_in, ang);
    chk({tag, "_err"}, 32'(err_timeout), 0);
    // Late input changes must not disturb the transaction.
    req_data      = ~req_data;
    req_operation = ~req_operation;
    t = 0;
    t_rdy = -1;
    while (t < 200 && done == 4'b0) begin
      @(negedge clk);
      t++;
      if (ready_CORDIC && t_rdy < 0) t_rdy = t;
    end
    if (done == 4'b0) begin
      checks++;
      errors++;
      $display("FAIL %s_done_timeout: got none expected done", tag);
      return;
    end
    chk({tag, "_done"}, 32'(done), 32'(1) << g);
    chk({tag, "_res"}, result, res);
    chk({tag, "_lat"}, 32'(t - t_rdy), 2);
    chk({tag, "_din_hold"}, data_in, ang);
    chk({tag, "_op_hold"}, 32'(operation), 32'(op));
    chk({tag, "_nbeg"}, 32'(beg_cnt - b0), 1);
    chk({tag, "_nack"}, 32'(ack_cnt - a0), 1);
    @(negedge clk);
    chk({tag, "_done_held"}, 32'(done), 32'(1) << g);
    req[g] = 1'b0;
    @(negedge clk);
    chk({tag, "_done_drop"}, 32'(done), 0);
    chk({tag, "_idle"}, 32'(busy), 0);
    chk({tag, "_res_keep"}, result, res);
  endtask

  typedef struct {
    logic [3:0]        set;
    logic [3:0]        op;
    logic [3:0][31:0]  ang;
    logic [31:0]       res;
    int                lat;
    int                g;
  } vec_t;

  vec_t tbl[9];
  int   expg[9] = '{0, 1, 2, 3, 0, 2, 3, 0, 1};
  logic [3:0] sets[9] = '{4'b1111, 4'b0000, 4'b0000,
                          4'b0000, 4'b0001, 4'b0100,
                          4'b1001, 4'b0000, 4'b0010};

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not end");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0][31:0] a;
    int k;
    for (int e = 0; e < 9; e++) begin
      tbl[e].set = sets[e];
      tbl[e].op  = 4'b0110 ^ 4'(e);
      for (int i = 0; i < 4; i++)
        tbl[e].ang[i] = 32'h4000_0000 + 32'(e * 16 + i);
      tbl[e].res = 32'hC0DE_0000 + 32'(e);
      tbl[e].lat = 3 + e;
      tbl[e].g   = expg[e];
    end
    tbl[8].op     = 4'b0010;
    tbl[8].ang[1] = 32'h3F00_0000;
    tbl[8].res    = 32'h3EF5_7744;
    tbl[8].lat    = 20;

    reset = 1'b1;
    req = '0;
    req_operation = '0;
    req_data = '0;
    core_res = '0;
    core_lat = 4;
    @(negedge clk);
    @(negedge clk);
    chk_idle("reset");
    reset = 1'b0;
    @(negedge clk);

    for (int e = 0; e < 9; e++) begin
      req           = req | tbl[e].set;
      req_operation = tbl[e].op;
      req_data      = tbl[e].ang;
      core_res      = tbl[e].res;
      core_lat      = tbl[e].lat;
      serve($sformatf("vec%0d", e), tbl[e].g,
            tbl[e].op[tbl[e].g],
            tbl[e].ang[tbl[e].g], tbl[e].res);
    end

    // Angle change after grant on req[2] (rr_ptr is 2).
    a = '0;
    a[2] = 32'h3F49_0FDB;
    req_data = a;
    req_operation = 4'b0100;
    req = 4'b0100;
    core_res = 32'h3F35_04F3;
    core_lat = 8;
    serve("angle", 2, 1'b1, 32'h3F49_0FDB, 32'h3F35_04F3);

    // Reset while waiting on the core.
    a = '0;
    a[0] = 32'h1234_5678;
    req_data = a;
    req_operation = 4'b0001;
    req = 4'b0001;
    core_lat = 50;
    @(negedge clk);
    chk("rst_beg", 32'(beg_FSM_CORDIC), 1);
    repeat (3) @(negedge clk);
    chk("rst_wait_busy", 32'(busy), 1);
    reset = 1'b1;
    req = '0;
    @(negedge clk);
    chk_idle("midrst");
    reset = 1'b0;
    @(negedge clk);
    chk("rst_stay_idle", 32'(busy), 0);

    // rr_ptr back to 0: 1010 grants 1 then 3.
    a = '0;
    a[1] = 32'h0000_1111;
    a[3] = 32'h0000_3333;
    req_data = a;
    req_operation = 4'b1000;
    req = 4'b1010;
    core_res = 32'h5555_AAAA;
    core_lat = 5;
    serve("post_rst1", 1, 1'b0, 32'h0000_1111, 32'h5555_AAAA);
    req_data = a;
    req_operation = 4'b1000;
    core_res = 32'h6666_BBBB;
    serve("post_rst3", 3, 1'b1, 32'h0000_3333, 32'h6666_BBBB);

`ifdef CORDIC_ARB_WATCHDOG_EN
    req_data = a;
    req = 4'b0001;
    core_lat = 100000;
    @(negedge clk);
    chk("wd_beg", 32'(beg_FSM_CORDIC), 1);
    k = 0;
    while (k < 40 && !ACK_FSM_CORDIC) begin
      @(negedge clk);
      k++;
    end
    chk("wd_ack_delay", 32'(k), 11);
    @(negedge clk);
    chk("wd_done", 32'(done), 32'b0001);
    chk("wd_err", 32'(err_timeout), 1);
    chk("wd_res", result, 0);
    req = '0;
    @(negedge clk);
    req_data = a;
    req_operation = 4'b0000;
    req = 4'b0010;
    core_res = 32'h7777_CCCC;
    core_lat = 3;
    serve("wd_next", 1, 1'b0, 32'h0000_1111, 32'h7777_CCCC);
`else
    k = 0;
    chk("no_wd_err", 32'(err_timeout), 32'(k));
`endif

    chk("onehot_done", 32'(onehot_bad), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
